// File: rtl/border_pkg.sv
// Shared types and constants for the border_stream Sobel edge pipeline.
package border_pkg;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Output modes
    localparam int MODE_MAG = 0;
    localparam int MODE_BIN = 1;

    // Extra bits over PIXEL_W for the signed Sobel sums. |Gx| and |Gy| are each
    // at most 4*(2^PIXEL_W-1), so their sum still fits without overflow.
    localparam int GRAD_EXTRA = 4;

endpackage

// File: rtl/line_buffer.sv
// One row of pixel storage, addressed by column. On an accepted pixel the old
// contents at addr (the pixel one row above) are read and then overwritten.
module line_buffer #(
    parameter int DEPTH  = 320,
    parameter int DATA_W = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Read-before-write: rd_data always shows the previous row's pixel.
    assign rd_data = mem[addr];

    // Store the incoming pixel in its column slot.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/border_stream.sv
// Streaming 3x3 Sobel filter with zeroed border, ready/valid on both sides.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_FILL  | accept first WIDTH+1 pixels of a frame, no output yet
//   ST_RUN   | one output per accepted input, 1-cycle latency
//   ST_DRAIN | input closed, emit the last WIDTH+1 (all border) outputs
module border_stream
    import border_pkg::*;
#(
    parameter int WIDTH   = 320,
    parameter int HEIGHT  = 240,
    parameter int PIXEL_W = 8,
    parameter int MODE    = 0,
    parameter int THRESH  = 128
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PIXEL_W-1:0] in_data,
    input  logic               in_sof,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PIXEL_W-1:0] out_data,
    output logic               out_sof,
    output logic               out_eol
);

    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam int DW = $clog2(WIDTH + 2);
    localparam int GW = PIXEL_W + GRAD_EXTRA;

    localparam logic [XW-1:0]      X_LAST    = XW'(WIDTH - 1);
    localparam logic [YW-1:0]      Y_LAST    = YW'(HEIGHT - 1);
    localparam logic [DW-1:0]      DRAIN_LEN = DW'(WIDTH + 1);
    localparam logic [PIXEL_W-1:0] PIX_MAX   = '1;
    localparam logic [PIXEL_W-1:0] THR       = PIXEL_W'(THRESH);
    localparam logic [GW-1:0]      MAG_CAP   = GW'((1 << PIXEL_W) - 1);

    state_t state, state_nxt;

    logic [XW-1:0] ix, ox;
    logic [YW-1:0] iy, oy;
    logic [DW-1:0] drain_left;

    logic accept, abort, frame_last_in, run_load, drain_load, load;

    logic [XW-1:0]      lb_addr;
    logic [PIXEL_W-1:0] row1, row2;

    // Window columns: c0 = x-1, c1 = x, new column (row2/row1/in_data) = x+1
    logic [PIXEL_W-1:0] c0_t, c0_m, c0_b, c1_t, c1_m, c1_b;

    logic signed [GW-1:0] gx, gy, agx, agy;
    logic [GW-1:0]        mag;
    logic [PIXEL_W-1:0]   sat, pix_out;
    logic                 border;

    function automatic logic signed [GW-1:0] ext(input logic [PIXEL_W-1:0] p);
        return $signed({{GRAD_EXTRA{1'b0}}, p});
    endfunction

    assign accept        = in_valid && in_ready;
    assign abort         = accept && in_sof && (ix != '0 || iy != '0);
    assign frame_last_in = (ix == X_LAST) && (iy == Y_LAST);
    assign run_load      = (state == ST_RUN) && accept && !abort;
    assign drain_load    = (state == ST_DRAIN) && (drain_left != '0) && (!out_valid || out_ready);
    assign load          = run_load || drain_load;
    assign lb_addr       = abort ? '0 : ix;

    line_buffer #(.DEPTH(WIDTH), .DATA_W(PIXEL_W)) u_lb0 (
        .clk     (clk),
        .wr_en   (accept),
        .addr    (lb_addr),
        .wr_data (in_data),
        .rd_data (row1)
    );

    line_buffer #(.DEPTH(WIDTH), .DATA_W(PIXEL_W)) u_lb1 (
        .clk     (clk),
        .wr_en   (accept),
        .addr    (lb_addr),
        .wr_data (row1),
        .rd_data (row2)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_FILL;
        else     state <= state_nxt;
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_FILL:  if (accept && !abort && ix == '0 && iy == YW'(1)) state_nxt = ST_RUN;
            ST_RUN: begin
                if (abort)                          state_nxt = ST_FILL;
                else if (accept && frame_last_in)   state_nxt = ST_DRAIN;
            end
            ST_DRAIN: if (drain_left == '0 && out_valid && out_ready) state_nxt = ST_FILL;
            default:  state_nxt = ST_FILL;
        endcase
    end

    // Input handshake per state; closed while reset is held
    always_comb begin
        in_ready = 1'b0;
        unique case (state)
            ST_FILL: in_ready = 1'b1;
            ST_RUN:  in_ready = !out_valid || out_ready;
            default: in_ready = 1'b0;
        endcase
        if (rst) in_ready = 1'b0;
    end

    // Input/output raster counters and drain down-counter
    always_ff @(posedge clk) begin
        if (rst) begin
            ix <= '0; iy <= '0; ox <= '0; oy <= '0; drain_left <= '0;
        end else if (abort) begin
            // the aborting pixel becomes index 0 of the new frame
            ix <= XW'(1); iy <= '0; ox <= '0; oy <= '0; drain_left <= '0;
        end else begin
            if (accept) begin
                if (ix == X_LAST) begin
                    ix <= '0;
                    iy <= (iy == Y_LAST) ? '0 : iy + 1'b1;
                end else begin
                    ix <= ix + 1'b1;
                end
            end
            if (load) begin
                if (ox == X_LAST) begin
                    ox <= '0;
                    oy <= (oy == Y_LAST) ? '0 : oy + 1'b1;
                end else begin
                    ox <= ox + 1'b1;
                end
            end
            if (run_load && frame_last_in) drain_left <= DRAIN_LEN;
            else if (drain_load)           drain_left <= drain_left - 1'b1;
        end
    end

    // Shift the 3x3 window by one column per accepted pixel
    always_ff @(posedge clk) begin
        if (accept) begin
            c0_t <= c1_t;  c0_m <= c1_m;  c0_b <= c1_b;
            c1_t <= row2;  c1_m <= row1;  c1_b <= in_data;
        end
    end

    // Sobel magnitude, saturation and mode select for the centre pixel
    always_comb begin
        gx = (ext(row2) + (ext(row1) <<< 1) + ext(in_data))
           - (ext(c0_t) + (ext(c0_m) <<< 1) + ext(c0_b));
        gy = (ext(c0_b) + (ext(c1_b) <<< 1) + ext(in_data))
           - (ext(c0_t) + (ext(c1_t) <<< 1) + ext(row2));
        agx = gx[GW-1] ? -gx : gx;
        agy = gy[GW-1] ? -gy : gy;
        mag = agx + agy;
        sat = (mag > MAG_CAP) ? PIX_MAX : mag[PIXEL_W-1:0];
        border = (ox == '0) || (ox == X_LAST) || (oy == '0) || (oy == Y_LAST);
        pix_out = '0;
        if (!border) begin
            if (MODE == MODE_BIN) pix_out = (sat >= THR) ? PIX_MAX : '0;
            else if (MODE == MODE_MAG) pix_out = sat;
            else pix_out = sat;
        end
    end

    // Output register: load, hold under backpressure, clear on abort
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
        end else if (abort) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= pix_out;
            out_sof   <= (ox == '0) && (oy == '0);
            out_eol   <= (ox == X_LAST);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_border_stream.sv
// Randomised bench for border_stream: three instances (magnitude, threshold
// 200, threshold 255) share the stimulus; a 2-D Sobel model predicts outputs.
module tb_border_stream;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int N  = W * H;
    localparam int PW = 8;

    typedef struct {
        logic [PW-1:0] mag;
        logic [PW-1:0] t200;
        logic [PW-1:0] t255;
        logic          sof;
        logic          eol;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_sof, out_ready;
    logic [PW-1:0] in_data;

    logic          in_ready, out_valid, out_sof, out_eol;
    logic [PW-1:0] out_data;
    logic          in_ready_t200, out_valid_t200, out_sof_t200, out_eol_t200;
    logic [PW-1:0] out_data_t200;
    logic          in_ready_t255, out_valid_t255, out_sof_t255, out_eol_t255;
    logic [PW-1:0] out_data_t255;

    int n_checks = 0;
    int n_fail   = 0;

    logic [PW-1:0] cur_pix [N];
    logic [PW-1:0] nxt_pix [N];
    int            ptr = N;
    int            abort_at = -1;
    bit            first_sof;
    bit            want_reset_state = 0;
    bit            want_idle = 0;
    bit            hold_pend = 0;
    exp_t          exp_q[$];

    always #5 clk = ~clk;

    border_stream #(.WIDTH(W), .HEIGHT(H), .PIXEL_W(PW), .MODE(0), .THRESH(128)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sof(in_sof), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sof(out_sof), .out_eol(out_eol)
    );

    border_stream #(.WIDTH(W), .HEIGHT(H), .PIXEL_W(PW), .MODE(1), .THRESH(200)) dut_t200 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_t200), .in_data(in_data),
        .in_sof(in_sof), .out_valid(out_valid_t200), .out_ready(out_ready), .out_data(out_data_t200),
        .out_sof(out_sof_t200), .out_eol(out_eol_t200)
    );

    border_stream #(.WIDTH(W), .HEIGHT(H), .PIXEL_W(PW), .MODE(1), .THRESH(255)) dut_t255 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_t255), .in_data(in_data),
        .in_sof(in_sof), .out_valid(out_valid_t255), .out_ready(out_ready), .out_data(out_data_t255),
        .out_sof(out_sof_t255), .out_eol(out_eol_t255)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] img_px(input int kind, input int k);
        int x;
        x = k % W;
        case (kind)
            0:       return 8'd50;
            1:       return (x >= 4) ? 8'd100 : 8'd0;
            2:       return (x >= 4) ? 8'd10 : 8'd0;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    function automatic int pix(input int x, input int y);
        return int'(cur_pix[y * W + x]);
    endfunction

    // Expected output stream of the frame in cur_pix, straight from the 2-D definition
    task automatic push_frame();
        exp_t e;
        int x, y, gx, gy, m;
        for (int k = 0; k < N; k++) begin
            x = k % W;
            y = k / W;
            m = 0;
            if (x > 0 && x < W - 1 && y > 0 && y < H - 1) begin
                gx = (pix(x+1, y-1) + 2 * pix(x+1, y) + pix(x+1, y+1))
                   - (pix(x-1, y-1) + 2 * pix(x-1, y) + pix(x-1, y+1));
                gy = (pix(x-1, y+1) + 2 * pix(x, y+1) + pix(x+1, y+1))
                   - (pix(x-1, y-1) + 2 * pix(x, y-1) + pix(x+1, y-1));
                m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
                if (m > 255) m = 255;
            end
            e.mag  = 8'(m);
            e.t200 = (m >= 200) ? 8'd255 : 8'd0;
            e.t255 = (m >= 255) ? 8'd255 : 8'd0;
            e.sof  = (k == 0);
            e.eol  = (x == W - 1);
            exp_q.push_back(e);
        end
    endtask

    // One clock: drive at negedge, sample 1 ns later, DUT acts on next posedge
    task automatic cycle(input bit rand_io, input bit do_rst, input bit feed);
        exp_t e;
        @(negedge clk);
        rst = do_rst;
        if (do_rst) begin
            in_valid  = 1'b0;
            in_sof    = 1'b0;
            out_ready = 1'b0;
        end else begin
            out_ready = rand_io ? 1'($urandom_range(0, 1)) : 1'b1;
            in_valid  = feed && (ptr < N) && (rand_io ? ($urandom_range(0, 3) != 0) : 1'b1);
            if (ptr == abort_at) begin
                in_data = nxt_pix[0];
                in_sof  = 1'b1;
            end else begin
                in_data = (ptr < N) ? cur_pix[ptr] : 8'd0;
                in_sof  = (ptr == 0) && first_sof;
            end
        end
        #1;
        if (do_rst) begin
            chk("in_ready_during_rst", in_ready, 0);
            chk("in_ready_t200_during_rst", in_ready_t200, 0);
            chk("in_ready_t255_during_rst", in_ready_t255, 0);
        end
        if (want_reset_state && !do_rst) begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_data", out_data, 0);
            chk("rst_out_sof", out_sof, 0);
            chk("rst_out_eol", out_eol, 0);
            chk("rst_in_ready", in_ready, 1);
            chk("rst_in_ready_t200", in_ready_t200, 1);
            chk("rst_in_ready_t255", in_ready_t255, 1);
            want_reset_state = 0;
        end
        if (want_idle) begin
            chk("abort_valid_clear", out_valid, 0);
            want_idle = 0;
        end
        if (hold_pend) chk("stall_valid_hold", out_valid, 1);
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", 1, 0);
            end else begin
                e = exp_q[0];
                chk("mag_data", out_data, e.mag);
                chk("out_sof", out_sof, e.sof);
                chk("out_eol", out_eol, e.eol);
                chk("t200_valid", out_valid_t200, 1);
                chk("t200_data", out_data_t200, e.t200);
                chk("t200_sof", out_sof_t200, e.sof);
                chk("t200_eol", out_eol_t200, e.eol);
                chk("t255_valid", out_valid_t255, 1);
                chk("t255_data", out_data_t255, e.t255);
                chk("t255_sof", out_sof_t255, e.sof);
                chk("t255_eol", out_eol_t255, e.eol);
                if (out_ready) e = exp_q.pop_front();
            end
        end
        hold_pend = !do_rst && (out_valid === 1'b1) && !out_ready;
        if (!do_rst && in_valid && in_ready) begin
            if (ptr == abort_at) begin
                for (int k = 0; k < N; k++) cur_pix[k] = nxt_pix[k];
                ptr      = 1;
                abort_at = -1;
                exp_q.delete();
                push_frame();
                want_idle = 1;
            end else begin
                ptr++;
            end
        end
    endtask

    task automatic feed_frame(input int kind, input bit sof_first, input bit rand_io,
                              input int ab_idx, input int ab_kind, input int rst_idx);
        int budget;
        for (int k = 0; k < N; k++) cur_pix[k] = img_px(kind, k);
        if (ab_idx >= 0) for (int k = 0; k < N; k++) nxt_pix[k] = img_px(ab_kind, k);
        ptr       = 0;
        first_sof = sof_first;
        abort_at  = ab_idx;
        push_frame();
        budget = 0;
        while (ptr < N) begin
            if (ptr == rst_idx) begin
                cycle(rand_io, 1'b1, 1'b0);
                exp_q.delete();
                want_reset_state = 1;
                ptr = N;
                return;
            end
            cycle(rand_io, 1'b0, 1'b1);
            budget++;
            if (budget > 3000) begin
                chk("feed_timeout", ptr, N);
                return;
            end
        end
    endtask

    initial begin
        int budget;
        rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) cycle(1'b0, 1'b1, 1'b0);
        want_reset_state = 1;

        feed_frame(0, 1'b0, 1'b0, -1, 0, -1);   // flat 50, first pixel without sof
        feed_frame(1, 1'b1, 1'b0, -1, 0, -1);   // 0/100 step
        feed_frame(2, 1'b1, 1'b0, -1, 0, -1);   // 0/10 step
        feed_frame(1, 1'b1, 1'b1, -1, 0, -1);   // 0/100 step under stalls
        feed_frame(3, 1'b1, 1'b1, -1, 0, -1);   // random image
        feed_frame(3, 1'b1, 1'b1, 20, 1, -1);   // abort at 20, restart with step
        feed_frame(3, 1'b1, 1'b1, -1, 0, 30);   // reset at 30
        feed_frame(1, 1'b0, 1'b1, -1, 0, -1);   // clean frame after reset
        feed_frame(3, 1'b1, 1'b1, -1, 0, -1);

        budget = 0;
        while ((exp_q.size() != 0 || out_valid === 1'b1) && budget < 500) begin
            cycle(1'b1, 1'b0, 1'b0);
            budget++;
        end
        chk("outputs_outstanding", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
